// File: rtl/byte_stream_arbiter.sv
// N-channel byte merger feeding one TX FIFO write port, with round-robin or fixed-priority arbitration.
// Define STREAM_TAG_EN to prefix a channel tag byte (TAG_BASE + channel) whenever the source changes.
module byte_stream_arbiter #(
    parameter int                    NUM_CH     = 2,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ARB_MODE   = 0,
    parameter logic [DATA_WIDTH-1:0] TAG_BASE   = 8'hF0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            src_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] src_data,
    output logic [NUM_CH-1:0]            src_ack,
    input  logic                         out_full,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_write_en,
    output logic                         busy
);

    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]     r_ack, w_ack_next;
    logic                  r_wen, w_wen_next;
    logic [DATA_WIDTH-1:0] r_data, w_data_next;
    logic [NUM_CH-1:0]     r_mask;
    logic [CW-1:0]         r_last_grant, w_last_grant_next;

    logic [NUM_CH-1:0]     w_elig;
    logic                  w_found;
    logic [CW-1:0]         w_sel;
    logic [CW-1:0]         w_idx;
    logic [DATA_WIDTH-1:0] w_sel_data;

`ifdef STREAM_TAG_EN
    typedef enum logic {ST_IDLE = 1'b0, ST_TAG = 1'b1} state_t;

    state_t                r_state, w_state_next;
    logic [CW-1:0]         r_grant, w_grant_next;
    logic [CW-1:0]         r_tag_ch, w_tag_ch_next;
    logic                  r_tag_vld, w_tag_vld_next;
    logic [DATA_WIDTH-1:0] w_grant_data;

    assign w_grant_data = src_data[r_grant*DATA_WIDTH +: DATA_WIDTH];
    assign busy         = (r_state == ST_TAG);
`else
    logic w_unused_tag;

    assign w_unused_tag = ^TAG_BASE;
    assign busy         = 1'b0;
`endif

    // The channel acked last cycle is still showing its old valid, so hide it for exactly one edge.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_elig
        assign w_elig[gi] = src_valid[gi] & ~r_mask[gi];
    end

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ARB_MODE == 1) begin
                w_idx = CW'(i);
            end else begin
                w_idx = CW'((int'(r_last_grant) + 1 + i) % NUM_CH);
            end
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    assign w_sel_data = src_data[w_sel*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        w_ack_next        = '0;
        w_wen_next        = 1'b0;
        w_data_next       = r_data;
        w_last_grant_next = r_last_grant;
`ifdef STREAM_TAG_EN
        w_state_next   = r_state;
        w_grant_next   = r_grant;
        w_tag_ch_next  = r_tag_ch;
        w_tag_vld_next = r_tag_vld;
        case (r_state)
            ST_IDLE: begin
                if (w_found && !out_full) begin
                    w_wen_next = 1'b1;
                    if (r_tag_vld && (r_tag_ch == w_sel)) begin
                        w_data_next       = w_sel_data;
                        w_ack_next[w_sel] = 1'b1;
                        w_last_grant_next = w_sel;
                    end else begin
                        w_data_next  = TAG_BASE + DATA_WIDTH'(w_sel);
                        w_grant_next = w_sel;
                        w_state_next = ST_TAG;
                    end
                end
            end
            ST_TAG: begin
                // Committed to r_grant: a newly valid higher-priority channel must wait.
                if (!out_full) begin
                    w_wen_next          = 1'b1;
                    w_data_next         = w_grant_data;
                    w_ack_next[r_grant] = 1'b1;
                    w_last_grant_next   = r_grant;
                    w_tag_ch_next       = r_grant;
                    w_tag_vld_next      = 1'b1;
                    w_state_next        = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
`else
        if (w_found && !out_full) begin
            w_wen_next        = 1'b1;
            w_data_next       = w_sel_data;
            w_ack_next[w_sel] = 1'b1;
            w_last_grant_next = w_sel;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ack        <= '0;
            r_wen        <= 1'b0;
            r_data       <= '0;
            r_mask       <= '0;
            r_last_grant <= CW'(NUM_CH - 1);
`ifdef STREAM_TAG_EN
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_tag_ch     <= '0;
            r_tag_vld    <= 1'b0;
`endif
        end else begin
            r_ack        <= w_ack_next;
            r_wen        <= w_wen_next;
            r_data       <= w_data_next;
            r_mask       <= w_ack_next;
            r_last_grant <= w_last_grant_next;
`ifdef STREAM_TAG_EN
            r_state      <= w_state_next;
            r_grant      <= w_grant_next;
            r_tag_ch     <= w_tag_ch_next;
            r_tag_vld    <= w_tag_vld_next;
`endif
        end
    end

    assign src_ack      = r_ack;
    assign out_write_en = r_wen;
    assign out_data     = r_data;

endmodule

// File: tb/tb_byte_stream_arbiter.sv
// Bench for byte_stream_arbiter: a round-robin and a fixed-priority instance, each fed by
// ack-driven source models, with expected writes queued at stimulus time and popped per write.
`timescale 1ns/1ps
module tb_byte_stream_arbiter;

    localparam logic [7:0] TAGB = 8'hF0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       out_full = 1'b0;
    logic [1:0] sv  [2];
    logic [15:0] sd [2];
    logic [1:0] ack [2];
    logic [7:0] od  [2];
    logic       wen [2];
    logic       bsy [2];

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] sq_mem  [2][2][64];
    int         sq_head [2][2];
    int         sq_tail [2][2];
    logic [9:0] exp_q0 [$];
    logic [9:0] exp_q1 [$];
    int         tag_last [2];

    always #5 clk = ~clk;

    byte_stream_arbiter #(.NUM_CH(2), .DATA_WIDTH(8), .ARB_MODE(0), .TAG_BASE(8'hF0)) dut0 (
        .clock(clk), .reset(rst), .src_valid(sv[0]), .src_data(sd[0]), .src_ack(ack[0]),
        .out_full(out_full), .out_data(od[0]), .out_write_en(wen[0]), .busy(bsy[0]));

    byte_stream_arbiter #(.NUM_CH(2), .DATA_WIDTH(8), .ARB_MODE(1), .TAG_BASE(8'hF0)) dut1 (
        .clock(clk), .reset(rst), .src_valid(sv[1]), .src_data(sd[1]), .src_ack(ack[1]),
        .out_full(1'b0), .out_data(od[1]), .out_write_en(wen[1]), .busy(bsy[1]));

    // Source model: valid while its queue is non-empty; pops on the edge after it sees ack.
    initial begin : src_drv
        logic seen [2][2];
        for (int d = 0; d < 2; d++) begin
            sv[d] = 2'b00;
            sd[d] = 16'h0000;
            for (int c = 0; c < 2; c++) begin
                sq_head[d][c] = 0;
                seen[d][c]    = 1'b0;
            end
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < 2; c++)
                    seen[d][c] = ack[d][c];
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < 2; c++) begin
                    if (seen[d][c] && sq_head[d][c] != sq_tail[d][c]) sq_head[d][c]++;
                    sv[d][c]        = (sq_head[d][c] != sq_tail[d][c]);
                    sd[d][c*8 +: 8] = sq_mem[d][c][sq_head[d][c]];
                end
            end
        end
    end

    // Output monitor: every write must match the next queued expectation.
    initial begin : mon
        logic [9:0] e;
        logic [1:0] prev [2];
        prev[0] = 2'b00;
        prev[1] = 2'b00;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (wen[d]) begin
                    compared++;
                    if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
                        mismatched++;
                        $display("FAIL unexpected_write dut%0d: got ack=%b data=%02h, required no write",
                                 d, ack[d], od[d]);
                    end else begin
                        if (d == 0) e = exp_q0.pop_front();
                        else        e = exp_q1.pop_front();
                        if ({ack[d], od[d]} !== e) begin
                            mismatched++;
                            $display("FAIL out_byte dut%0d: got ack=%b data=%02h, required ack=%b data=%02h",
                                     d, ack[d], od[d], e[9:8], e[7:0]);
                        end
                    end
                end else if (ack[d] !== 2'b00) begin
                    compared++;
                    mismatched++;
                    $display("FAIL ack_without_write dut%0d: got ack=%b, required 00", d, ack[d]);
                end
                if (ack[d] !== 2'b00) begin
                    compared++;
                    if ((ack[d] & prev[d]) != 2'b00 || ack[d] == 2'b11) begin
                        mismatched++;
                        $display("FAIL ack_pattern dut%0d: got ack=%b after %b, required one bit, not repeated",
                                 d, ack[d], prev[d]);
                    end
                end
                prev[d] = ack[d];
            end
        end
    end

    task automatic push_src(input int d, input int c, input logic [7:0] b);
        sq_mem[d][c][sq_tail[d][c]] = b;
        sq_tail[d][c]++;
    endtask

    task automatic exp_push(input int d, input logic [9:0] v);
        if (d == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
    endtask

    function automatic int exp_size(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    task automatic exp_byte(input int d, input int c, input logic [7:0] b);
`ifdef STREAM_TAG_EN
        if (tag_last[d] != c) begin
            exp_push(d, {2'b00, TAGB + 8'(c)});
            tag_last[d] = c;
        end
`endif
        exp_push(d, {2'(1 << c), b});
    endtask

    task automatic wait_drain(input int d);
        int n = 0;
        while (n < 200 && !(exp_size(d) == 0 && sq_head[d][0] == sq_tail[d][0]
                            && sq_head[d][1] == sq_tail[d][1])) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            compared++;
            if ({ack[d], wen[d], od[d], bsy[d]} !== 12'h000) begin
                mismatched++;
                $display("FAIL reset_outputs dut%0d: got ack=%b wen=%b data=%02h busy=%b, required all 0",
                         d, ack[d], wen[d], od[d], bsy[d]);
            end
        end
        rst = 1'b0;
        for (int d = 0; d < 2; d++) tag_last[d] = -1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            compared++;
            if ({ack[d], wen[d]} !== 3'b000) begin
                mismatched++;
                $display("FAIL idle_after_reset dut%0d: got ack=%b wen=%b, required 0", d, ack[d], wen[d]);
            end
        end
    endtask

    task automatic test_round_robin();
        int n, seen, cyc, first, last;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            push_src(0, 0, 8'h41);
            push_src(0, 1, 8'h42);
            exp_byte(0, 0, 8'h41);
            exp_byte(0, 1, 8'h42);
        end
        n = exp_size(0); seen = 0; cyc = 0; first = -1; last = -1;
        while (seen < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (wen[0]) begin
                if (first < 0) first = cyc;
                last = cyc;
                seen++;
            end
        end
        compared++;
        if (seen != n || last - first != n - 1) begin
            mismatched++;
            $display("FAIL rr_throughput: got %0d writes over %0d cycles, required %0d back-to-back",
                     seen, last - first + 1, n);
        end
        wait_drain(0);
        compared++;
        if (exp_size(0) != 0) begin
            mismatched++;
            $display("FAIL rr_drain: got %0d writes missing, required 0", exp_size(0));
        end
    endtask

    task automatic test_single_no_double_read();
        @(negedge clk);
        push_src(0, 0, 8'h55);
        exp_byte(0, 0, 8'h55);
        wait_drain(0);
        repeat (4) @(negedge clk);
        compared++;
        if (exp_size(0) != 0 || sq_head[0][0] != sq_tail[0][0]) begin
            mismatched++;
            $display("FAIL single_byte: got %0d writes missing, source pending %0d, required 0/0",
                     exp_size(0), sq_tail[0][0] - sq_head[0][0]);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            push_src(0, 0, 8'h01 + 8'(i));
            push_src(0, 1, 8'h11 + 8'(i));
        end
        // last grant was ch0, so round-robin serves ch1 first
        for (int i = 0; i < 3; i++) begin
            exp_byte(0, 1, 8'h11 + 8'(i));
            exp_byte(0, 0, 8'h01 + 8'(i));
        end
        wait_drain(0);
        compared++;
        if (exp_size(0) != 0) begin
            mismatched++;
            $display("FAIL b2b_drain: got %0d writes missing, required 0", exp_size(0));
        end
    endtask

    task automatic test_backpressure();
        logic [9:0] first_exp;
        @(negedge clk);
        out_full = 1'b1;
        push_src(0, 1, 8'h42);
        exp_byte(0, 1, 8'h42);
        first_exp = exp_q0[0];
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            compared++;
            if (wen[0] !== 1'b0 || ack[0] !== 2'b00) begin
                mismatched++;
                $display("FAIL full_hold cycle %0d: got wen=%b ack=%b, required 0/00", i, wen[0], ack[0]);
            end
        end
        out_full = 1'b0;
        @(negedge clk);
        compared++;
        if ({wen[0], ack[0], od[0]} !== {1'b1, first_exp}) begin
            mismatched++;
            $display("FAIL full_release: got wen=%b ack=%b data=%02h, required 1/%b/%02h",
                     wen[0], ack[0], od[0], first_exp[9:8], first_exp[7:0]);
        end
        wait_drain(0);
        compared++;
        if (exp_size(0) != 0) begin
            mismatched++;
            $display("FAIL full_drain: got %0d writes missing, required 0", exp_size(0));
        end
    endtask

    task automatic test_fixed_priority();
        @(negedge clk);
        push_src(1, 0, 8'h10);
        exp_byte(1, 0, 8'h10);
        wait_drain(1);
        // round-robin would now favour ch1; fixed priority must still pick ch0
        for (int i = 0; i < 3; i++) begin
            push_src(1, 0, 8'hA0 + 8'(i));
            push_src(1, 1, 8'hB0 + 8'(i));
        end
        for (int i = 0; i < 3; i++) begin
            exp_byte(1, 0, 8'hA0 + 8'(i));
            exp_byte(1, 1, 8'hB0 + 8'(i));
        end
        wait_drain(1);
        compared++;
        if (exp_size(1) != 0) begin
            mismatched++;
            $display("FAIL fp_drain: got %0d writes missing, required 0", exp_size(1));
        end
    endtask

`ifdef STREAM_TAG_EN
    task automatic test_tag_sequence();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_src(0, 1, 8'h11);
        exp_push(0, {2'b00, 8'hF1});
        exp_push(0, {2'b10, 8'h11});
        wait_drain(0);
        push_src(0, 1, 8'h12);
        exp_push(0, {2'b10, 8'h12});
        wait_drain(0);
        push_src(0, 0, 8'h21);
        exp_push(0, {2'b00, 8'hF0});
        exp_push(0, {2'b01, 8'h21});
        wait_drain(0);
        tag_last[0] = 0;
        tag_last[1] = -1;
        compared++;
        if (exp_size(0) != 0) begin
            mismatched++;
            $display("FAIL tag_seq_drain: got %0d writes missing, required 0", exp_size(0));
        end
    endtask

    task automatic test_reset_in_tag();
        int n = 0;
        @(negedge clk);
        push_src(0, 1, 8'h33);
        exp_push(0, {2'b00, 8'hF1});
        while (n < 50 && !(wen[0] && od[0] == 8'hF1)) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (n >= 50 || bsy[0] !== 1'b1) begin
            mismatched++;
            $display("FAIL tag_write: got busy=%b after %0d cycles, required tag F1 with busy=1", bsy[0], n);
        end
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if ({ack[0], wen[0], bsy[0]} !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_in_tag: got ack=%b wen=%b busy=%b, required 00/0/0", ack[0], wen[0], bsy[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_push(0, {2'b00, 8'hF1});
        exp_push(0, {2'b10, 8'h33});
        tag_last[0] = 1;
        tag_last[1] = -1;
        wait_drain(0);
        compared++;
        if (exp_size(0) != 0 || sq_head[0][1] != sq_tail[0][1]) begin
            mismatched++;
            $display("FAIL retag_after_reset: got %0d writes missing, required 0", exp_size(0));
        end
    endtask
`endif

    initial begin
        for (int d = 0; d < 2; d++) begin
            tag_last[d] = -1;
            for (int c = 0; c < 2; c++) sq_tail[d][c] = 0;
        end
        test_reset();
        test_round_robin();
        test_single_no_double_read();
        test_back_to_back();
        test_backpressure();
        test_fixed_priority();
`ifdef STREAM_TAG_EN
        test_tag_sequence();
        test_reset_in_tag();
`endif
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
